picosoc_mem_dp: RTL and testbench
=================================

Name: picosoc_mem_dp

Overview:
Parametrised successor to the PicoSoC on-chip SRAM. It provides one read/write port on the picorv32 native valid/ready handshake with byte strobes and programmable wait states. It adds a second read-only port for DMA or video fetch, with an optional output register. It also flags out-of-range word addresses, and is generic in data width and depth.

Parameters:
WORDS, 256, number of memory words; must be at least 2.
DATA_W, 32, word width in bits; must be a multiple of 8 (NB = DATA_W/8 byte lanes).
ADDR_W, 22, width of both word-address inputs.
WAIT_STATES, 0, extra cycles (0..15) inserted before port A ready.
B_OUT_REG, 0, 0 gives port B latency 1; 1 adds an output register, giving latency 2.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
reset  in  1  synchronous reset, active-high.
a_valid  in  1  port A request; held high by the master until a_ready.
a_ready  out  1  one-cycle pulse that completes a port A request.
a_wstrb  in  NB  byte write enables; all zero means a read.
a_addr  in  ADDR_W  port A word address.
a_wdata  in  DATA_W  port A write data.
a_rdata  out  DATA_W  port A read data; valid while a_ready is high.
a_err  out  1  high together with a_ready when a_addr >= WORDS.
b_en  in  1  port B read request; one request per cycle, no backpressure.
b_addr  in  ADDR_W  port B word address.
b_rdata  out  DATA_W  port B read data.
b_rvalid  out  1  b_rdata is valid this cycle.

Behaviour:
- Reset: a_ready=0, a_err=0, a_rdata=0, b_rvalid=0, b_rdata=0, any B_OUT_REG stage cleared, FSM to IDLE. Memory contents are not cleared.
- Port A FSM has three states: IDLE, WAIT, RESP.
- IDLE with a_valid=1 (acceptance edge):
  - If in range: array read of a_addr and the strobed byte writes happen on this edge. The read returns the old word (read-before-write).
  - Go to RESP if WAIT_STATES=0; otherwise load a counter with WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter; go to RESP when it reaches 0.
- RESP: a_ready=1 for exactly one cycle, then back to IDLE.
  - A new request is never accepted in the RESP cycle.
  - Minimum spacing between acceptances is 2+WAIT_STATES cycles.
  - Port A latency: a_ready arrives 1+WAIT_STATES cycles after the acceptance edge.
- Captured response values:
  - a_rdata is captured at the acceptance edge and held stable until the next acceptance.
  - For a write, a_rdata returns the pre-write word.
- Out of range on port A (a_addr >= WORDS, full ADDR_W compare):
  - No write, a_rdata=0, a_err=1 during the RESP cycle.
  - Timing is otherwise identical to an in-range request.
- a_valid is sampled only in IDLE. Changes to a_addr, a_wdata or a_wstrb after the acceptance edge have no effect.
- Port B:
  - b_en sampled at edge t: b_rvalid=1 and b_rdata=mem[b_addr] in cycle t+1 (B_OUT_REG=0) or t+2 (B_OUT_REG=1).
  - Fully pipelined: b_en held high gives one result per cycle.
  - When b_rvalid=0, b_rdata holds its last value.
- Port B boundaries:
  - b_addr >= WORDS returns 0 with b_rvalid=1.
  - A port B read of the same word that port A writes on the same edge returns the old word.
  - Consecutive-cycle reads after a write see the new data.
- Reset mid-operation:
  - Aborts any pending port A response; no a_ready is issued for it.
  - A write already committed at its acceptance edge stays committed.
  - Port B pipeline contents are dropped.

Decomposition:
- Shared package picosoc_mem_pkg holds:
  - FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Function clog2 for counter and index widths.
  - WAIT_STATES legal maximum (15).
- Sub-module picosoc_mem_bank:
  - Raw WORDS x DATA_W array.
  - One read/write port with NB byte enables and one read-only port.
  - Registered read-before-write outputs, no reset.
- Top level adds the FSM, wait counter, range checks, error flag and the B output stage.

Test Plan:
- WAIT_STATES=0: write a_addr=5, a_wdata=32'hDEADBEEF, a_wstrb=4'hF, then read addr 5 -> a_ready exactly 1 cycle after each acceptance, read a_rdata=32'hDEADBEEF, a_err=0.
- Byte strobes: after the previous word, write a_wstrb=4'b0101 with a_wdata=32'h11223344 -> readback 32'hDE22BE44; the write's own a_rdata equals 32'hDEADBEEF.
- WAIT_STATES=3, a_valid held high continuously -> a_ready pulses every 5 cycles, never two in a row.
- Out of range, WORDS=256: a_addr=256 with a_wstrb=4'hF -> a_ready with a_err=1, a_rdata=0, mem[0] unchanged.
- Port B with B_OUT_REG=1:
  - b_en high for 4 cycles on addr 0..3 -> 4 consecutive b_rvalid starting 2 cycles later, data in order.
  - Same-edge port A write to addr 2 -> port B returns the old value for that read and the new value on a read 1 cycle later.
- Reset asserted in the WAIT state after a write to addr 7 -> no a_ready, outputs zero, later read of addr 7 returns the written data.

Source files
------------

// File: rtl/picosoc_mem_pkg.sv
// picosoc_mem_pkg: shared types and helpers for the dual-port
// PicoSoC SRAM (port A FSM encoding, widths, limits).
package picosoc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } a_state_e;

    localparam int WAIT_MAX = 15;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int WAIT_W = clog2(WAIT_MAX + 1);

endpackage

// File: rtl/picosoc_mem_bank.sv
// picosoc_mem_bank: raw WORDS x DATA_W array, one byte-strobed
// read/write port and one read-only port, registered outputs.
module picosoc_mem_bank
    import picosoc_mem_pkg::*;
#(
    parameter int WORDS  = 256,
    parameter int DATA_W = 32,
    parameter int IW     = clog2(WORDS),
    parameter int NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              a_en,
    input  logic [NB-1:0]     a_we,
    input  logic [IW-1:0]     a_idx,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_q,
    input  logic              b_en,
    input  logic [IW-1:0]     b_idx,
    output logic [DATA_W-1:0] b_q
);

    logic [DATA_W-1:0] mem [WORDS];

    // Both reads see the pre-edge contents, so a same-edge write
    // is invisible to either port until the following cycle.
    always_ff @(posedge clk) begin
        if (a_en) begin
            a_q <= mem[a_idx];
            for (int i = 0; i < NB; i++) begin
                if (a_we[i]) begin
                    mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
        if (b_en) begin
            b_q <= mem[b_idx];
        end
    end

endmodule

// File: rtl/picosoc_mem_dp.sv
// picosoc_mem_dp: PicoSoC SRAM with a valid/ready R/W port A
// (wait states, range error) and a pipelined read-only port B.
module picosoc_mem_dp
    import picosoc_mem_pkg::*;
#(
    parameter int WORDS       = 256,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 22,
    parameter int WAIT_STATES = 0,
    parameter int B_OUT_REG   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DATA_W/8-1:0]   a_wstrb,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic [DATA_W-1:0]     a_rdata,
    output logic                  a_err,
    input  logic                  b_en,
    input  logic [ADDR_W-1:0]     b_addr,
    output logic [DATA_W-1:0]     b_rdata,
    output logic                  b_rvalid
);

    localparam int NB = DATA_W / 8;
    localparam int IW = clog2(WORDS);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(WORDS);

    a_state_e          state;
    a_state_e          state_nx;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] cnt_nx;
    logic              accept;
    logic              a_take;
    logic              a_hit;
    logic              a_oor;
    logic              a_blank;
    logic [DATA_W-1:0] a_q;

    logic              b_hit;
    logic              b_v1;
    logic              b_blank1;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] b_d1;

    assign a_hit  = {1'b0, a_addr} < LIMIT;
    assign b_hit  = {1'b0, b_addr} < LIMIT;
    assign a_take = accept && !reset;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (a_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = WAIT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // a_blank zeroes a_rdata after reset and for out-of-range
    // requests, since the bank output itself is never reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            a_oor   <= 1'b0;
            a_blank <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                a_oor   <= !a_hit;
                a_blank <= !a_hit;
            end
        end
    end

    assign a_ready = (state == RESP);
    assign a_err   = (state == RESP) && a_oor;
    assign a_rdata = a_blank ? '0 : a_q;

    picosoc_mem_bank #(
        .WORDS  (WORDS),
        .DATA_W (DATA_W),
        .IW     (IW),
        .NB     (NB)
    ) u_bank (
        .clk     (clk),
        .a_en    (a_take && a_hit),
        .a_we    (a_wstrb),
        .a_idx   (a_addr[IW-1:0]),
        .a_wdata (a_wdata),
        .a_q     (a_q),
        .b_en    (b_en && b_hit && !reset),
        .b_idx   (b_addr[IW-1:0]),
        .b_q     (b_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            b_v1     <= 1'b0;
            b_blank1 <= 1'b1;
        end else begin
            b_v1 <= b_en;
            if (b_en) begin
                b_blank1 <= !b_hit;
            end
        end
    end

    assign b_d1 = b_blank1 ? '0 : b_q;

    if (B_OUT_REG != 0) begin : g_oreg
        logic              v2;
        logic [DATA_W-1:0] d2;

        always_ff @(posedge clk) begin
            if (reset) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= b_v1;
                if (b_v1) begin
                    d2 <= b_d1;
                end
            end
        end

        assign b_rvalid = v2;
        assign b_rdata  = d2;
    end else begin : g_direct
        assign b_rvalid = b_v1;
        assign b_rdata  = b_d1;
    end

endmodule

// File: tb/tb_picosoc_mem_dp.sv
// tb_picosoc_mem_dp: two instances (WS=0/B reg, WS=3/no B reg)
// checked against an array-and-queue reference model.
module tb_picosoc_mem_dp;

    localparam int W  = 256;
    localparam int DW = 32;
    localparam int AW = 22;
    localparam int NB = 4;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } bent_t;

    logic          clk = 1'b0;
    logic          reset    [2];
    logic          a_valid  [2];
    logic          a_ready  [2];
    logic [NB-1:0] a_wstrb  [2];
    logic [AW-1:0] a_addr   [2];
    logic [DW-1:0] a_wdata  [2];
    logic [DW-1:0] a_rdata  [2];
    logic          a_err    [2];
    logic          b_en     [2];
    logic [AW-1:0] b_addr   [2];
    logic [DW-1:0] b_rdata  [2];
    logic          b_rvalid [2];

    int            ws  [2] = '{0, 3};
    int            lat [2] = '{2, 1};
    logic [DW-1:0] m   [2][W];
    bent_t         bq  [2][$];
    logic [DW-1:0] bl  [2];
    bit            b_auto;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    picosoc_mem_dp #(
        .WORDS(W), .DATA_W(DW), .ADDR_W(AW),
        .WAIT_STATES(0), .B_OUT_REG(1)
    ) dut0 (
        .clk(clk), .reset(reset[0]),
        .a_valid(a_valid[0]), .a_ready(a_ready[0]),
        .a_wstrb(a_wstrb[0]), .a_addr(a_addr[0]),
        .a_wdata(a_wdata[0]), .a_rdata(a_rdata[0]),
        .a_err(a_err[0]), .b_en(b_en[0]),
        .b_addr(b_addr[0]), .b_rdata(b_rdata[0]),
        .b_rvalid(b_rvalid[0])
    );

    picosoc_mem_dp #(
        .WORDS(W), .DATA_W(DW), .ADDR_W(AW),
        .WAIT_STATES(3), .B_OUT_REG(0)
    ) dut1 (
        .clk(clk), .reset(reset[1]),
        .a_valid(a_valid[1]), .a_ready(a_ready[1]),
        .a_wstrb(a_wstrb[1]), .a_addr(a_addr[1]),
        .a_wdata(a_wdata[1]), .a_rdata(a_rdata[1]),
        .a_err(a_err[1]), .b_en(b_en[1]),
        .b_addr(b_addr[1]), .b_rdata(b_rdata[1]),
        .b_rvalid(b_rvalid[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return {AW{1'b1}};
        if (r == 1) return AW'(W + int'($urandom_range(0, 50)));
        return AW'($urandom_range(0, W - 1));
    endfunction

    // One clock; port B is modelled as a fixed-latency queue.
    task automatic tick();
        logic          rs [2];
        bent_t         s  [2];
        bent_t         e;
        for (int d = 0; d < 2; d++) begin
            if (b_auto) begin
                b_en[d]   = 1'($urandom_range(0, 1));
                b_addr[d] = pick_addr();
            end
            rs[d]  = reset[d];
            s[d].v = b_en[d] && !reset[d];
            s[d].d = (b_addr[d] < AW'(W)) ? m[d][b_addr[d][7:0]] : '0;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rs[d]) begin
                bq[d].delete();
                for (int k = 1; k < lat[d]; k++) bq[d].push_back('0);
                bl[d] = '0;
                e = '0;
            end else begin
                bq[d].push_back(s[d]);
                e = bq[d].pop_front();
                if (e.v) bl[d] = e.d;
            end
            chk($sformatf("b_rvalid%0d", d), 64'(b_rvalid[d]), 64'(e.v));
            chk($sformatf("b_rdata%0d", d), 64'(b_rdata[d]), 64'(bl[d]));
        end
    endtask

    task automatic a_xfer(input int d, input logic [AW-1:0] ad,
                          input logic [NB-1:0] st,
                          input logic [DW-1:0] wd, input bit chk_rd,
                          output logic [DW-1:0] rd);
        logic          oor;
        logic [DW-1:0] exp_rd;
        int            n;
        oor    = ad >= AW'(W);
        exp_rd = oor ? '0 : m[d][ad[7:0]];
        a_valid[d] = 1'b1;
        a_addr[d]  = ad;
        a_wstrb[d] = st;
        a_wdata[d] = wd;
        tick();
        if (!oor) begin
            for (int i = 0; i < NB; i++) begin
                if (st[i]) m[d][ad[7:0]][8*i +: 8] = wd[8*i +: 8];
            end
        end
        a_addr[d]  = AW'($urandom);
        a_wstrb[d] = NB'($urandom);
        a_wdata[d] = $urandom;
        n = 1;
        while (!a_ready[d] && n < 40) begin
            tick();
            n++;
        end
        chk($sformatf("a_lat%0d", d), 64'(n), 64'(1 + ws[d]));
        chk($sformatf("a_err%0d", d), 64'(a_err[d]), 64'(oor));
        if (chk_rd) begin
            chk($sformatf("a_rdata%0d", d), 64'(a_rdata[d]), 64'(exp_rd));
        end
        rd = a_rdata[d];
        a_valid[d] = 1'b0;
        tick();
        chk($sformatf("a_pulse%0d", d), 64'(a_ready[d]), 64'(0));
        chk($sformatf("a_hold%0d", d), 64'(a_rdata[d]), 64'(rd));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] old;
        logic [DW-1:0] wd;
        int            prev;
        int            np;
        for (int d = 0; d < 2; d++) begin
            reset[d]   = 1'b1;
            a_valid[d] = 1'b0;
            a_wstrb[d] = '0;
            a_addr[d]  = '0;
            a_wdata[d] = '0;
            b_en[d]    = 1'b0;
            b_addr[d]  = '0;
            bl[d]      = '0;
        end
        b_auto = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b0;
            chk($sformatf("rst_ready%0d", d), 64'(a_ready[d]), 64'(0));
            chk($sformatf("rst_err%0d", d), 64'(a_err[d]), 64'(0));
            chk($sformatf("rst_rdata%0d", d), 64'(a_rdata[d]), 64'(0));
        end

        for (int i = 0; i < W; i++) begin
            for (int d = 0; d < 2; d++) begin
                a_xfer(d, AW'(i), 4'hF, $urandom, 1'b0, rd);
            end
        end

        a_xfer(0, 5, 4'hF, 32'hDEADBEEF, 1'b1, rd);
        a_xfer(0, 5, 4'h0, 32'h0, 1'b1, rd);
        chk("rd5", 64'(rd), 64'(32'hDEADBEEF));
        a_xfer(0, 5, 4'b0101, 32'h11223344, 1'b1, rd);
        chk("wr_old", 64'(rd), 64'(32'hDEADBEEF));
        a_xfer(0, 5, 4'h0, 32'h0, 1'b1, rd);
        chk("strobe", 64'(rd), 64'(32'hDE22BE44));

        old = m[0][0];
        a_xfer(0, 256, 4'hF, $urandom, 1'b1, rd);
        chk("oor_rdata", 64'(rd), 64'(0));
        a_xfer(0, 0, 4'h0, 32'h0, 1'b1, rd);
        chk("oor_nowrite", 64'(rd), 64'(old));

        a_valid[1] = 1'b1;
        a_addr[1]  = 10;
        a_wstrb[1] = '0;
        prev = -1;
        np   = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (a_ready[1]) begin
                if (prev < 0) chk("ws3_first", 64'(k), 64'(4));
                else chk("ws3_gap", 64'(k - prev), 64'(5));
                chk("ws3_rdata", 64'(a_rdata[1]), 64'(m[1][10]));
                prev = k;
                np++;
            end
        end
        chk("ws3_count", 64'(np), 64'(6));
        a_valid[1] = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            b_en[0]   = 1'b1;
            b_addr[0] = AW'(i);
            tick();
        end
        b_en[0] = 1'b0;
        repeat (3) tick();

        old = m[0][2];
        b_en[0]   = 1'b1;
        b_addr[0] = 2;
        a_xfer(0, 2, 4'hF, ~old, 1'b1, rd);
        chk("same_edge_a", 64'(rd), 64'(old));
        b_en[0] = 1'b0;
        repeat (3) tick();

        wd = $urandom;
        a_valid[1] = 1'b1;
        a_addr[1]  = 7;
        a_wstrb[1] = 4'hF;
        a_wdata[1] = wd;
        tick();
        m[1][7] = wd;
        tick();
        reset[1] = 1'b1;
        tick();
        reset[1]   = 1'b0;
        a_valid[1] = 1'b0;
        chk("mid_rst_rdata", 64'(a_rdata[1]), 64'(0));
        chk("mid_rst_err", 64'(a_err[1]), 64'(0));
        for (int k = 0; k < 6; k++) begin
            chk("mid_rst_ready", 64'(a_ready[1]), 64'(0));
            tick();
        end
        a_xfer(1, 7, 4'h0, 32'h0, 1'b1, rd);
        chk("mid_rst_kept", 64'(rd), 64'(wd));

        b_auto = 1'b1;
        for (int k = 0; k < 300; k++) begin
            int            d;
            logic [NB-1:0] st;
            d  = int'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? '0 : NB'($urandom);
            a_xfer(d, pick_addr(), st, $urandom, 1'b1, rd);
        end
        b_auto = 1'b0;
        b_en[0] = 1'b0;
        b_en[1] = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
